// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scanner with a double-buffered BCD value (swapped only at frame start).
// Load handshake: load_ready = !pending_vld, loads stall while pending is full; an/seg are combinational from state.
module seg_scan_ctrl #(
  parameter int DRIVE_CYC = 1000,
  parameter int DEAD_CYC  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        disp_en,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int MAX_CYC = (DRIVE_CYC > DEAD_CYC) ? DRIVE_CYC : DEAD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] DEAD_END  = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] DRIVE_END = CW'(DRIVE_CYC - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [15:0]   display;
  logic [15:0]   pending;
  logic          pending_vld;
  logic          frame_start;

  // idx already points at the next digit while blanking, so idx==0 here marks a new frame
  assign frame_start = (state == BLANK) && (cnt == DEAD_END) && (idx == 2'd0);
  assign load_ready  = ~pending_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BLANK;
      idx         <= 2'd0;
      cnt         <= '0;
      display     <= 16'h0000;
      pending     <= 16'h0000;
      pending_vld <= 1'b0;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == DEAD_END) begin
            state <= DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_END) begin
            state <= BLANK;
            idx   <= idx + 2'd1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase

      if (frame_start && pending_vld) begin
        display     <= pending;
        pending_vld <= 1'b0;
      end else if (load_valid && !pending_vld) begin
        pending     <= load_data;
        pending_vld <= 1'b1;
      end
    end
  end

  logic [3:0] cur_digit;
  logic       lz_blank;
  logic [6:0] seg_code;

  assign cur_digit = display[{idx, 2'b00} +: 4];

  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd1:    lz_blank = (display[15:4]  == 12'h000);
      2'd2:    lz_blank = (display[15:8]  == 8'h00);
      2'd3:    lz_blank = (display[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  end

  always_comb begin
    seg_code = 7'b0000000;
    case (cur_digit)
      4'd0:    seg_code = 7'b0111111;
      4'd1:    seg_code = 7'b0000110;
      4'd2:    seg_code = 7'b1011011;
      4'd3:    seg_code = 7'b1001111;
      4'd4:    seg_code = 7'b1100110;
      4'd5:    seg_code = 7'b1101101;
      4'd6:    seg_code = 7'b1111101;
      4'd7:    seg_code = 7'b0000111;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1101111;
      default: seg_code = 7'b0000000;
    endcase
  end

  assign an  = (state == DRIVE && disp_en) ? (4'b0001 << idx) : 4'b0000;
  assign seg = (state == DRIVE && !(lz_en && lz_blank)) ? seg_code : 7'b0000000;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl; expected an/seg/load_ready come from a frame-position model.
module tb_seg_scan_ctrl;

  localparam int DRV  = 4;
  localparam int DED  = 1;
  localparam int SLOT = DRV + DED;
  localparam int PER  = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        disp_en;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;

  seg_scan_ctrl #(.DRIVE_CYC(DRV), .DEAD_CYC(DED)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .disp_en    (disp_en),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          k;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_pv;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, k);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Position within the frame decides everything: first DED cycles of each slot are blank
  function automatic logic [3:0] exp_an();
    int pos = k % PER;
    int slot = pos / SLOT;
    int off = pos % SLOT;
    if (off < DED || !disp_en) return 4'b0000;
    return 4'(1 << slot);
  endfunction

  function automatic logic [6:0] exp_seg();
    int pos = k % PER;
    int slot = pos / SLOT;
    int off = pos % SLOT;
    logic [15:0] upper;
    if (off < DED) return 7'b0000000;
    upper = m_disp >> (4 * slot);
    if (lz_en && slot >= 1 && upper == 16'h0000) return 7'b0000000;
    return dec(upper[3:0]);
  endfunction

  task automatic model_reset();
    k = 0;
    m_disp = 16'h0000;
    m_pend = 16'h0000;
    m_pv = 1'b0;
  endtask

  // Called right after a rising edge, with inputs as they were at that edge
  task automatic model_edge();
    k++;
    if (k % PER == DED && m_pv) begin
      m_disp = m_pend;
      m_pv = 1'b0;
    end else if (load_valid && !m_pv) begin
      m_pend = load_data;
      m_pv = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("an", {12'h0, an}, {12'h0, exp_an()});
    check("seg", {9'h0, seg}, {9'h0, exp_seg()});
    check("load_ready", {15'h0, load_ready}, {15'h0, ~m_pv});
  endtask

  function automatic logic [15:0] gen_data();
    logic [15:0] d;
    int n;
    case ($urandom_range(0, 3))
      0: d = 16'($urandom);
      1: d = 16'h0070;
      default: begin
        for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
        n = $urandom_range(0, 4);
        for (int j = 0; j < n; j++) d[15 - 4*j -: 4] = 4'h0;
      end
    endcase
    return d;
  endfunction

  task automatic run_cycles(input int n, input bit rand_in);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
      if (rand_in) begin
        load_valid = ($urandom_range(0, 5) == 0);
        load_data  = gen_data();
        if ($urandom_range(0, 29) == 0) disp_en = ~disp_en;
        if ($urandom_range(0, 29) == 0) lz_en = ~lz_en;
      end
    end
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = 16'h0000;
    disp_en = 1'b1;
    lz_en = 1'b0;
    model_reset();
    #12;
    check("rst_an", {12'h0, an}, 16'h0000);
    check("rst_seg", {9'h0, seg}, 16'h0000);
    check("rst_ready", {15'h0, load_ready}, 16'h0001);

    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_outputs();

    // One quiet frame showing 0000 everywhere
    run_cycles(PER + 2, 1'b0);

    // Directed double load: second offer while pending full must be ignored
    load_valid = 1'b1;
    load_data = 16'h1234;
    run_cycles(1, 1'b0);
    load_data = 16'h5678;
    run_cycles(1, 1'b0);
    load_valid = 1'b0;
    run_cycles(2 * PER, 1'b0);

    run_cycles(2500, 1'b1);

    // Reset pulse while digit 2 is driven and pending is full
    disp_en = 1'b1;
    load_valid = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      load_data = gen_data();
      run_cycles(1, 1'b0);
      if ((k % PER) / SLOT == 2 && (k % PER) % SLOT >= DED && m_pv) hit = 1'b1;
    end
    check("rst_target_reached", {15'h0, hit}, 16'h0001);
    load_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_an", {12'h0, an}, 16'h0000);
    check("midrst_seg", {9'h0, seg}, 16'h0000);
    check("midrst_ready", {15'h0, load_ready}, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    check("midrst_hold_an", {12'h0, an}, 16'h0000);
    rst = 1'b0;
    model_reset();
    check_outputs();
    run_cycles(PER + 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
